// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: command decoder sitting behind a byte-oriented SPI slave.
// Each frame starts with a command byte: bit7 = write(1)/read(0), bits[6:3]
// must be zero, bits[2:0] = start address. Subsequent bytes are written to,
// or trigger reads from, an auto-incrementing address into an 8-entry file.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   frame_active chip-select active, synchronised to clk
//   rx_byte      received byte, qualified by rx_valid
//   rx_valid     one-cycle strobe per received byte
//   tx_byte      next byte for the slave to shift out
//   tx_load      one-cycle strobe, tx_byte updated this cycle
//   led          reg0[3:0]
//   busy         high outside IDLE
module spi_cmd_ctrl #(
  parameter logic [7:0] ID_VALUE = 8'hA5,
  parameter logic [7:0] GREETING = 8'h5A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_active,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic [7:0] tx_byte,
  output logic       tx_load,
  output logic [3:0] led,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, CMD, WRITE, READ, IGNORE} state_t;

  state_t     state_q, state_d;
  logic       fa_prev_q;
  logic [7:0] rw_q [4];
  logic [7:0] rw_d [4];
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [2:0] addr_q, addr_d;
  logic       rd_pend_q, rd_pend_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       tx_load_q, tx_load_d;
  logic [7:0] rd_data;
  logic       frame_rise, cmd_bad, frame_end;

  assign frame_rise = frame_active & ~fa_prev_q;
  assign cmd_bad    = |rx_byte[6:3];
  assign frame_end  = (state_q != IDLE) & ~frame_active;

  // Register file read mux; sees pre-write values of the current cycle.
  always_comb begin
    unique case (addr_q)
      3'd4:    rd_data = frame_cnt_q;
      3'd5:    rd_data = err_cnt_q;
      3'd6:    rd_data = ID_VALUE;
      3'd7:    rd_data = 8'h00;
      default: rd_data = rw_q[addr_q[1:0]];
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (frame_rise) state_d = CMD;
      CMD:  if (rx_valid) state_d = cmd_bad ? IGNORE : (rx_byte[7] ? WRITE : READ);
      default: ;
    endcase
    // Frame end wins, but the byte's own action still happens in the datapath.
    if (frame_end) state_d = IDLE;
  end

  // Output / datapath next-state logic
  always_comb begin
    rw_d        = rw_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    addr_d      = addr_q;
    tx_byte_d   = tx_byte_q;
    tx_load_d   = 1'b0;
    rd_pend_d   = 1'b0;

    // Read load lands one cycle after the strobe that requested it.
    if (rd_pend_q) begin
      tx_byte_d = rd_data;
      tx_load_d = 1'b1;
      addr_d    = addr_q + 3'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (frame_rise) begin
          tx_byte_d = GREETING;
          tx_load_d = 1'b1;
        end
      end
      CMD: begin
        if (rx_valid) begin
          if (cmd_bad) begin
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          end else begin
            addr_d    = rx_byte[2:0];
            // A read strobe that coincides with frame end is dropped.
            rd_pend_d = ~rx_byte[7] & frame_active;
          end
        end
      end
      WRITE: begin
        if (rx_valid) begin
          if (!addr_q[2]) rw_d[addr_q[1:0]] = rx_byte;
          addr_d = addr_q + 3'd1;
        end
      end
      READ: begin
        if (rx_valid && frame_active) rd_pend_d = 1'b1;
      end
      default: ;
    endcase

    if (frame_end) frame_cnt_d = frame_cnt_q + 8'd1;
  end

  // Datapath registers; fa_prev_q resets high so a frame open at reset is skipped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fa_prev_q   <= 1'b1;
      rw_q        <= '{default: 8'h00};
      frame_cnt_q <= 8'h00;
      err_cnt_q   <= 8'h00;
      addr_q      <= 3'd0;
      rd_pend_q   <= 1'b0;
      tx_byte_q   <= 8'h00;
      tx_load_q   <= 1'b0;
    end else begin
      fa_prev_q   <= frame_active;
      rw_q        <= rw_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
      addr_q      <= addr_d;
      rd_pend_q   <= rd_pend_d;
      tx_byte_q   <= tx_byte_d;
      tx_load_q   <= tx_load_d;
    end
  end

  assign tx_byte = tx_byte_q;
  assign tx_load = tx_load_q;
  assign led     = rw_q[0][3:0];
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Randomised + directed bench for spi_cmd_ctrl against a frame-level model.
module tb_spi_cmd_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       frame_active;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [7:0] tx_byte;
  logic       tx_load;
  logic [3:0] led;
  logic       busy;

  always #5 clk = ~clk;

  spi_cmd_ctrl dut (
    .clk(clk), .rst(rst), .frame_active(frame_active), .rx_byte(rx_byte),
    .rx_valid(rx_valid), .tx_byte(tx_byte), .tx_load(tx_load), .led(led), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame-level reference model
  localparam int K_W = 1, K_R = 2, K_IG = 3;
  logic [7:0] m_reg [4];
  logic [7:0] m_frames, m_err, e_tx, pend_val;
  logic [2:0] m_addr;
  bit         inframe, pend, prev_fa, e_load;
  int         nb, kind;

  function automatic logic [7:0] m_rd(input logic [2:0] a);
    case (a)
      3'd4:    return m_frames;
      3'd5:    return m_err;
      3'd6:    return 8'hA5;
      3'd7:    return 8'h00;
      default: return m_reg[a[1:0]];
    endcase
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
    m_frames = 0; m_err = 0; m_addr = 0; e_tx = 0; pend_val = 0;
    inframe = 0; pend = 0; prev_fa = 1; e_load = 0; nb = 0; kind = 0;
  endtask

  // One clock cycle: update model, drive, check at the following negedge.
  task automatic cyc(input bit fa, input bit v, input logic [7:0] b);
    bit np = 0;
    logic [7:0] npv = 8'h00;
    e_load = 0;
    if (pend) begin e_load = 1; e_tx = pend_val; end
    if (!inframe) begin
      if (fa && !prev_fa) begin inframe = 1; nb = 0; e_load = 1; e_tx = 8'h5A; end
    end else begin
      if (v) begin
        if (nb == 0) begin
          if (b[6:3] != 4'd0) begin
            kind = K_IG;
            if (m_err != 8'hFF) m_err = m_err + 1;
          end else begin
            m_addr = b[2:0];
            kind = b[7] ? K_W : K_R;
          end
        end else if (kind == K_W) begin
          if (m_addr < 4) m_reg[m_addr[1:0]] = b;
          m_addr = m_addr + 1;
        end
        if (kind == K_R && fa) begin np = 1; npv = m_rd(m_addr); m_addr = m_addr + 1; end
        nb++;
      end
      if (!fa) begin inframe = 0; m_frames = m_frames + 1; end
    end
    pend = np; pend_val = npv; prev_fa = fa;
    frame_active = fa; rx_valid = v; rx_byte = b;
    @(posedge clk);
    @(negedge clk);
    chk("tx_load", tx_load, e_load);
    chk("tx_byte", tx_byte, e_tx);
    chk("busy", busy, inframe);
    chk("led", led, m_reg[0][3:0]);
  endtask

  task automatic send(input logic [7:0] b);
    cyc(1, 1, b);
    cyc(1, 0, 8'h00);
  endtask

  task automatic do_reset();
    rst = 1; frame_active = 0; rx_valid = 0; rx_byte = 0;
    m_reset();
    @(negedge clk);
    chk("rst_tx_byte", tx_byte, 8'h00);
    chk("rst_tx_load", tx_load, 1'b0);
    chk("rst_led", led, 4'h0);
    chk("rst_busy", busy, 1'b0);
    rst = 0;
    cyc(0, 0, 8'h00);
  endtask

  // Read one register in its own frame, returns observed load value.
  task automatic rd_frame(input logic [2:0] a, output logic [7:0] val);
    cyc(1, 0, 8'h00);
    cyc(1, 1, {5'b0, a});
    cyc(1, 0, 8'h00);
    val = tx_byte;
    cyc(0, 0, 8'h00);
  endtask

  initial begin
    logic [7:0] v;
    do_reset();

    // Greeting and first write
    cyc(1, 0, 8'h00);
    chk("greet", tx_byte, 8'h5A);
    chk("greet_load", tx_load, 1'b1);
    send(8'h80); send(8'h0B);
    cyc(0, 0, 8'h00);
    chk("wr_led", led, 4'hB);

    // Burst write then burst read
    cyc(1, 0, 8'h00); send(8'h81); send(8'h11); send(8'h22); cyc(0, 0, 8'h00);
    cyc(1, 0, 8'h00);
    send(8'h01); chk("rd1", tx_byte, 8'h11);
    send(8'h00); chk("rd2", tx_byte, 8'h22);
    send(8'h00); chk("rd3", tx_byte, 8'h00);
    cyc(0, 0, 8'h00);

    // ID read with address wrap
    do_reset();
    cyc(1, 0, 8'h00);
    send(8'h06); chk("id", tx_byte, 8'hA5);
    send(8'hC3); chk("wrap7", tx_byte, 8'h00);
    send(8'h3C); chk("wrap0", tx_byte, 8'h00);
    cyc(0, 0, 8'h00);

    // Bad command, error count and saturation
    cyc(1, 0, 8'h00); send(8'h48); send(8'hFF); cyc(0, 0, 8'h00);
    rd_frame(3'd5, v); chk("err1", v, 8'h01);
    rd_frame(3'd0, v); chk("ign_reg0", v, 8'h00);
    for (int i = 0; i < 256; i++) begin
      cyc(1, 0, 8'h00); cyc(1, 1, 8'h48); cyc(0, 0, 8'h00);
    end
    rd_frame(3'd5, v); chk("err_sat", v, 8'hFF);

    // Frame count and coincident end-of-frame write
    do_reset();
    for (int i = 0; i < 3; i++) begin cyc(1, 0, 8'h00); cyc(0, 0, 8'h00); end
    rd_frame(3'd4, v); chk("frames3", v, 8'h03);
    cyc(1, 0, 8'h00); send(8'h80); cyc(0, 1, 8'h3C);
    chk("coinc_idle", busy, 1'b0);
    rd_frame(3'd0, v); chk("coinc_data", v, 8'h3C);

    // Reset in the middle of a write frame with frame_active held high
    cyc(1, 0, 8'h00); send(8'h81); cyc(1, 1, 8'h77);
    rst = 1; m_reset(); #1;
    chk("mid_tx_byte", tx_byte, 8'h00);
    chk("mid_tx_load", tx_load, 1'b0);
    chk("mid_led", led, 4'h0);
    chk("mid_busy", busy, 1'b0);
    @(negedge clk); rst = 0;
    for (int i = 0; i < 3; i++) cyc(1, 0, 8'h00);
    cyc(0, 0, 8'h00);
    cyc(1, 0, 8'h00); chk("reopen", tx_byte, 8'h5A);
    cyc(0, 0, 8'h00);
    rd_frame(3'd1, v); chk("mid_reg1", v, 8'h00);

    // Randomised frames
    for (int f = 0; f < 120; f++) begin
      int kd, nbytes;
      logic [7:0] cmd;
      kd = $urandom_range(0, 3);
      cmd = $urandom_range(0, 255);
      case (kd)
        0: cmd = {1'b1, 4'b0, cmd[2:0]};
        1: cmd = {1'b0, 4'b0, cmd[2:0]};
        2: if (cmd[6:3] == 4'd0) cmd[5] = 1'b1;
        default: ;
      endcase
      nbytes = $urandom_range(0, 4);
      cyc(1, 0, 8'h00);
      for (int j = 0; j <= nbytes; j++) begin
        logic [7:0] b;
        b = (j == 0) ? cmd : 8'($urandom_range(0, 255));
        if (j == nbytes && $urandom_range(0, 3) == 0) begin
          cyc(0, 1, b);
        end else begin
          cyc(1, 1, b);
          for (int g = $urandom_range(0, 2); g > 0; g--) cyc(1, 0, 8'h00);
          if (j == nbytes) cyc(0, 0, 8'h00);
        end
      end
      if ($urandom_range(0, 4) == 0) cyc(0, 1, 8'($urandom_range(0, 255)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
